// File: rtl/alu_uart_sequencer_pkg.sv
// Shared types and constants for the ALU/UART frame sequencer.
// Frame layout is SYNC, result[15:8], result[7:0]. The high byte is optional.
package alu_uart_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_ACK   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t IDX_SYNC = 2'd0;
  localparam byte_idx_t IDX_HI   = 2'd1;
  localparam byte_idx_t IDX_LO   = 2'd2;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/alu_uart_sequencer_seq_ack_timer.sv
// Loadable 4-bit down-counter that bounds the wait for the UART busy acknowledge.
// With load_val = N, expired is raised on the N-th enabled cycle after the load.
module seq_ack_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [3:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  cnt <= 4'd0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign expired = en && (cnt == 4'd1);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Takes one ALU request at a time and captures the 16-bit result.
// The result is then sent to UART_TX as a SYNC-framed byte stream.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter bit          SEND_HIGH   = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [2:0]  req_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [15:0] alu_result,
  output logic        uart_start,
  output logic [7:0]  uart_data,
  input  logic        uart_busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] result_q,
  output logic [7:0]  frame_count
);

  state_t    state, state_nx;
  byte_idx_t byte_idx;
  logic      accept, tmr_load, tmr_expired;

  assign accept = req_valid && req_ready;

  seq_ack_timer u_ack_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (4'(ACK_TIMEOUT)),
    .en       (state == ST_ACK),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    uart_start = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    tmr_load   = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_EXEC;
      ST_EXEC:  state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_START;
      ST_START: begin
        uart_start = 1'b1;
        tmr_load   = 1'b1;
        state_nx   = ST_ACK;
      end
      // Busy seen on the final timer cycle still counts as an acknowledge.
      ST_ACK: begin
        if (uart_busy) state_nx = ST_DRAIN;
        else if (tmr_expired) begin
          frame_err = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!uart_busy) begin
          if (byte_idx == IDX_LO) begin
            frame_done = 1'b1;
            state_nx   = ST_IDLE;
          end else begin
            state_nx = ST_LOAD;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // req_ready is registered so that it stays low out of reset until the first real IDLE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready   <= 1'b0;
      alu_a       <= 8'd0;
      alu_b       <= 8'd0;
      alu_opcode  <= 3'd0;
      result_q    <= 16'd0;
      uart_data   <= 8'd0;
      byte_idx    <= IDX_SYNC;
      frame_count <= 8'd0;
    end else begin
      req_ready <= (state_nx == ST_IDLE);
      if (state == ST_IDLE && accept) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        alu_opcode <= req_opcode;
      end
      if (state == ST_EXEC) begin
        result_q <= alu_result;
        byte_idx <= IDX_SYNC;
      end
      if (state == ST_LOAD) begin
        case (byte_idx)
          IDX_SYNC: uart_data <= SYNC_BYTE;
          IDX_HI:   uart_data <= result_q[15:8];
          default:  uart_data <= result_q[7:0];
        endcase
      end
      if (state == ST_DRAIN && !uart_busy && byte_idx != IDX_LO)
        byte_idx <= (byte_idx == IDX_SYNC && !SEND_HIGH) ? IDX_LO : byte_idx + 2'd1;
      if (frame_done)
        frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed scoreboard bench: two sequencers (with and without high byte) driving a simple UART model.
module tb_alu_uart_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rv[2];
  logic [7:0]  ra, rb;
  logic [2:0]  rop;
  logic        rdy[2], start[2], busy[2], done[2], err[2];
  logic [7:0]  aa[2], ab[2], data[2], fc[2];
  logic [2:0]  aop[2];
  logic [15:0] ares[2], rq[2];

  bit          busy_en[2];
  int          busy_len;
  int          bcnt[2];
  int          cyc, n_cmp, n_bad;
  int          nstart[2], ndone[2], nerr, last_start, err_dt;
  logic [7:0]  exp_q[$];

  always #5 clock = ~clock;

  function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return {8'd0, a} + {8'd0, b};
      OP_SUB:  return {8'd0, a} - {8'd0, b};
      OP_MUL:  return {8'd0, a} * {8'd0, b};
      default: return 16'd0;
    endcase
  endfunction

  assign ares[0] = alu(aa[0], ab[0], aop[0]);
  assign ares[1] = alu(aa[1], ab[1], aop[1]);

  alu_uart_sequencer #(.SEND_HIGH(1'b1)) u0 (
    .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_a(ra), .req_b(rb), .req_opcode(rop),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_opcode(aop[0]), .alu_result(ares[0]),
    .uart_start(start[0]), .uart_data(data[0]), .uart_busy(busy[0]),
    .frame_done(done[0]), .frame_err(err[0]), .result_q(rq[0]), .frame_count(fc[0])
  );

  alu_uart_sequencer #(.SEND_HIGH(1'b0)) u1 (
    .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_a(ra), .req_b(rb), .req_opcode(rop),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_opcode(aop[1]), .alu_result(ares[1]),
    .uart_start(start[1]), .uart_data(data[1]), .uart_busy(busy[1]),
    .frame_done(done[1]), .frame_err(err[1]), .result_q(rq[1]), .frame_count(fc[1])
  );

  // UART_TX stand-in: busy rises the cycle after start and holds for busy_len cycles.
  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        busy[i] <= 1'b0;
        bcnt[i] <= 0;
      end else if (start[i] && busy_en[i]) begin
        busy[i] <= 1'b1;
        bcnt[i] <= busy_len;
      end else if (bcnt[i] != 0) begin
        bcnt[i] <= bcnt[i] - 1;
        busy[i] <= (bcnt[i] != 1);
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each start pops the scoreboard. Only one DUT runs at a time, so a single queue serves both.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (start[i]) begin
          check("start_while_busy", 16'(busy[i]), 16'd0);
          check("exp_q_empty_at_start", 16'(exp_q.size() == 0), 16'd0);
          if (exp_q.size() != 0) check($sformatf("byte_dut%0d", i), 16'(data[i]), 16'(exp_q.pop_front()));
          nstart[i]++;
          last_start = cyc;
        end
        if (done[i] || err[i]) check("done_err_exclusive", 16'(done[i] & err[i]), 16'd0);
        if (done[i]) ndone[i]++;
        if (err[i]) begin
          nerr++;
          err_dt = cyc - last_start;
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit ok = 1'b0;
    @(negedge clock);
    ra = a; rb = b; rop = op; rv[i] = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (rdy[i]) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    check("req_accept", 16'(ok), 16'd1);
    @(posedge clock);
    #1 rv[i] = 1'b0;
  endtask

  task automatic wait_end(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clock);
      if (done[i] || err[i]) got = 1'b1;
    end
    check("wait_end", 16'(got), 16'd1);
  endtask

  task automatic check_zero(input int i);
    check("rst_req_ready", 16'(rdy[i]), 16'd0);
    check("rst_uart_start", 16'(start[i]), 16'd0);
    check("rst_uart_data", 16'(data[i]), 16'd0);
    check("rst_alu_a", 16'(aa[i]), 16'd0);
    check("rst_alu_b", 16'(ab[i]), 16'd0);
    check("rst_alu_opcode", 16'(aop[i]), 16'd0);
    check("rst_result_q", rq[i], 16'd0);
    check("rst_frame_count", 16'(fc[i]), 16'd0);
    check("rst_frame_done", 16'(done[i]), 16'd0);
    check("rst_frame_err", 16'(err[i]), 16'd0);
  endtask

  initial begin
    int s, d, e;
    bit seen;
    rv[0] = 1'b0; rv[1] = 1'b0; ra = 8'd0; rb = 8'd0; rop = 3'd0;
    busy_en[0] = 1'b1; busy_en[1] = 1'b1; busy_len = 4;
    cyc = 0; n_cmp = 0; n_bad = 0; nstart[0] = 0; nstart[1] = 0;
    ndone[0] = 0; ndone[1] = 0; nerr = 0; last_start = 0; err_dt = 0;

    @(posedge clock); #1;
    check_zero(0);
    check_zero(1);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 16'(rdy[0]), 16'd1);

    // ADD 12+34: three bytes, first start 3 cycles after accept
    s = nstart[0];
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h46);
    send(0, 8'h12, 8'h34, OP_ADD);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check($sformatf("latency_c%0d", k), 16'(start[0]), (k == 3) ? 16'd1 : 16'd0);
    end
    wait_end(0);
    @(negedge clock);
    check("add_starts", 16'(nstart[0] - s), 16'd3);
    check("add_frame_count", 16'(fc[0]), 16'd1);
    check("add_result_q", rq[0], 16'h0046);
    check("add_ready_after", 16'(rdy[0]), 16'd1);

    // MUL FF*02 with and without high byte
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
    send(0, 8'hFF, 8'h02, OP_MUL);
    wait_end(0);
    @(negedge clock);
    check("mul_frame_count", 16'(fc[0]), 16'd2);
    check("mul_result_q", rq[0], 16'h01FE);

    s = nstart[1];
    exp_q.push_back(8'hA5); exp_q.push_back(8'hFE);
    send(1, 8'hFF, 8'h02, OP_MUL);
    wait_end(1);
    @(negedge clock);
    check("lo_only_starts", 16'(nstart[1] - s), 16'd2);
    check("lo_only_frame_count", 16'(fc[1]), 16'd1);
    check("lo_only_result_q", rq[1], 16'h01FE);

    // Back-to-back with req_valid held high
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h07);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    @(negedge clock);
    ra = 8'h03; rb = 8'h04; rop = OP_ADD; rv[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (rdy[0]) seen = 1'b1; else @(negedge clock);
    end
    check("b2b_first_accept", 16'(seen), 16'd1);
    @(posedge clock); #1;
    ra = 8'h00; rb = 8'h01; rop = OP_SUB;
    d = ndone[0];
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clock);
      if (rdy[0]) seen = 1'b1;
    end
    check("b2b_second_ready", 16'(seen), 16'd1);
    check("b2b_after_done", 16'(ndone[0] - d), 16'd1);
    @(posedge clock); #1 rv[0] = 1'b0;
    check("b2b_alu_a", 16'(aa[0]), 16'h0000);
    check("b2b_alu_b", 16'(ab[0]), 16'h0001);
    wait_end(0);
    @(negedge clock);
    check("b2b_frame_count", 16'(fc[0]), 16'd4);
    check("b2b_result_q", rq[0], 16'hFFFF);

    // Ack timeout: UART never goes busy
    busy_en[0] = 1'b0;
    e = nerr; d = ndone[0];
    exp_q.push_back(8'hA5);
    send(0, 8'h01, 8'h01, OP_ADD);
    wait_end(0);
    @(negedge clock);
    check("timeout_ready_next", 16'(rdy[0]), 16'd1);
    check("timeout_err_count", 16'(nerr - e), 16'd1);
    check("timeout_delay", 16'(err_dt), 16'd15);
    check("timeout_frame_count", 16'(fc[0]), 16'd4);
    check("timeout_no_done", 16'(ndone[0] - d), 16'd0);
    busy_en[0] = 1'b1;

    // Async reset while the high byte is draining
    s = nstart[0];
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h07);
    send(0, 8'h03, 8'h04, OP_ADD);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock); #1;
      if (nstart[0] - s >= 2) seen = 1'b1;
    end
    check("mid_reset_reach_hi", 16'(seen), 16'd1);
    @(negedge clock);
    @(negedge clock);
    d = ndone[0];
    #2 reset = 1'b1;
    #1;
    check_zero(0);
    exp_q.delete();
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("mid_reset_no_done", 16'(ndone[0] - d), 16'd0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h10);
    send(0, 8'h80, 8'h90, OP_ADD);
    wait_end(0);
    @(negedge clock);
    check("post_reset_frame_count", 16'(fc[0]), 16'd1);
    check("post_reset_result_q", rq[0], 16'h0110);

    // frame_count wrap on the short-frame instance
    busy_len = 1;
    for (int n = 1; n <= 256; n++) begin
      exp_q.push_back(8'hA5); exp_q.push_back(8'(n));
      send(1, 8'(n), 8'h00, OP_ADD);
      wait_end(1);
      if (n == 255) begin
        @(negedge clock);
        check("wrap_255", 16'(fc[1]), 16'd255);
      end
    end
    @(negedge clock);
    check("wrap_0", 16'(fc[1]), 16'd0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
